opb_single_master: RTL

Single-beat OPB bus master. It lets fabric logic issue one 32-bit read or write at a time to any OPB slave, such as the simulink2ppc/ppc2simulink register cores on the same OPB segment. It is the initiator end of the slave-side protocol the register cores implement. It handles request/grant arbitration, retry, error acknowledge and timeout, and returns a status code per command. It sits on the OPB master port of the XPS base system, clocked by OPB_Clk.

---
 rtl/opb_single_master.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/opb_single_master.sv
// Single-beat OPB bus master: one read or write per command, with
// request/grant arbitration, slave retry, error ack and watchdog timeout.
// OPB buses are big-endian numbered; vector index N-1 here is OPB bit 0, so
// numeric values pass through unchanged.
module opb_single_master #(
  parameter int C_OPB_AWIDTH = 32,
  parameter int C_OPB_DWIDTH = 32,
  parameter int C_TIMEOUT    = 32,
  parameter int C_MAX_RETRY  = 4,
  parameter     C_FAMILY     = "virtex5"
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_rnw,
  input  logic [C_OPB_AWIDTH-1:0]     cmd_addr,
  input  logic [C_OPB_DWIDTH-1:0]     cmd_wdata,
  input  logic [C_OPB_DWIDTH/8-1:0]   cmd_be,
  output logic                        rsp_valid,
  output logic [C_OPB_DWIDTH-1:0]     rsp_rdata,
  output logic [1:0]                  rsp_status,
  output logic                        M_request,
  output logic                        M_busLock,
  output logic                        M_select,
  output logic                        M_RNW,
  output logic                        M_seqAddr,
  output logic [C_OPB_AWIDTH-1:0]     M_ABus,
  output logic [C_OPB_DWIDTH/8-1:0]   M_BE,
  output logic [C_OPB_DWIDTH-1:0]     M_DBus,
  input  logic                        OPB_MGrant,
  input  logic                        OPB_xferAck,
  input  logic                        OPB_errAck,
  input  logic                        OPB_retry,
  input  logic                        OPB_timeout,
  input  logic [C_OPB_DWIDTH-1:0]     OPB_DBus
);

  localparam int BEW = C_OPB_DWIDTH / 8;
  localparam logic [7:0] WDOG_LAST = 8'(C_TIMEOUT - 1);
  localparam logic [3:0] RETRY_MAX = 4'(C_MAX_RETRY);
  // Family name only selects the implementation target; it has no logic.
  localparam bit unused_family = |C_FAMILY;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERRACK  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_RETRY   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER} state_t;

  state_t                  state_q, state_d;
  logic                    rnw_q, rnw_d;
  logic [C_OPB_AWIDTH-1:0] addr_q, addr_d;
  logic [C_OPB_DWIDTH-1:0] wdata_q, wdata_d;
  logic [BEW-1:0]          be_q, be_d;
  logic [3:0]              retry_q, retry_d;
  logic [7:0]              wdog_q, wdog_d;
  logic                    m_request_q, m_request_d;
  logic                    m_select_q, m_select_d;
  logic                    m_rnw_q, m_rnw_d;
  logic [C_OPB_AWIDTH-1:0] m_abus_q, m_abus_d;
  logic [BEW-1:0]          m_be_q, m_be_d;
  logic [C_OPB_DWIDTH-1:0] m_dbus_q, m_dbus_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [C_OPB_DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_status_q, rsp_status_d;

  // Ready only in IDLE and never while reset is asserted.
  assign cmd_ready  = (state_q == S_IDLE) && !OPB_Rst;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_status = rsp_status_q;
  assign M_request  = m_request_q;
  assign M_select   = m_select_q;
  assign M_RNW      = m_rnw_q;
  assign M_ABus     = m_abus_q;
  assign M_BE       = m_be_q;
  assign M_DBus     = m_dbus_q;
  assign M_busLock  = 1'b0;
  assign M_seqAddr  = 1'b0;

  // Next-state, bus drive and response generation.
  always_comb begin
    state_d      = state_q;
    rnw_d        = rnw_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    retry_d      = retry_q;
    wdog_d       = wdog_q;
    m_request_d  = m_request_q;
    m_select_d   = m_select_q;
    m_rnw_d      = m_rnw_q;
    m_abus_d     = m_abus_q;
    m_be_d       = m_be_q;
    m_dbus_d     = m_dbus_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_status_d = rsp_status_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          rnw_d       = cmd_rnw;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          be_d        = cmd_be;
          retry_d     = '0;
          wdog_d      = '0;
          m_request_d = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        // No watchdog here: waiting on the arbiter is unbounded.
        if (OPB_MGrant) begin
          m_request_d = 1'b0;
          m_select_d  = 1'b1;
          m_rnw_d     = rnw_q;
          m_abus_d    = addr_q;
          m_be_d      = be_q;
          m_dbus_d    = rnw_q ? '0 : wdata_q;
          wdog_d      = '0;
          state_d     = S_XFER;
        end
      end
      S_XFER: begin
        wdog_d = wdog_q + 8'd1;
        if (OPB_retry && (retry_q < RETRY_MAX)) begin
          retry_d     = retry_q + 4'd1;
          m_request_d = 1'b1;
          state_d     = S_REQ;
        end else if (OPB_retry) begin
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_RETRY;
          rsp_rdata_d  = '0;
        end else if (OPB_xferAck) begin
          rsp_valid_d  = 1'b1;
          rsp_status_d = OPB_errAck ? ST_ERRACK : ST_OK;
          rsp_rdata_d  = (rnw_q && !OPB_errAck) ? OPB_DBus : '0;
        end else if (OPB_timeout || (wdog_q == WDOG_LAST)) begin
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_TIMEOUT;
          rsp_rdata_d  = '0;
        end
        // Leaving XFER for any reason releases the OR-bus.
        if (state_d != S_XFER || rsp_valid_d) begin
          m_select_d = 1'b0;
          m_rnw_d    = 1'b0;
          m_abus_d   = '0;
          m_be_d     = '0;
          m_dbus_d   = '0;
        end
        if (rsp_valid_d) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q      <= S_IDLE;
      rnw_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      retry_q      <= '0;
      wdog_q       <= '0;
      m_request_q  <= 1'b0;
      m_select_q   <= 1'b0;
      m_rnw_q      <= 1'b0;
      m_abus_q     <= '0;
      m_be_q       <= '0;
      m_dbus_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= '0;
    end else begin
      state_q      <= state_d;
      rnw_q        <= rnw_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      retry_q      <= retry_d;
      wdog_q       <= wdog_d;
      m_request_q  <= m_request_d;
      m_select_q   <= m_select_d;
      m_rnw_q      <= m_rnw_d;
      m_abus_q     <= m_abus_d;
      m_be_q       <= m_be_d;
      m_dbus_q     <= m_dbus_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
    end
  end

endmodule
